// File: rtl/fret_input_pkg.sv
// Shared constants and types for the fret/strum input conditioner.
package fret_input_pkg;

    localparam int unsigned N_FRETS_DEF  = 5;
    localparam int unsigned DEBOUNCE_DEF = 500000;
    localparam int unsigned PRESS_CNT_W  = 16;

    typedef logic [N_FRETS_DEF-1:0] fret_vec_t;

endpackage : fret_input_pkg

// File: rtl/fret_debounce_ch.sv
// One input channel: 2-FF synchroniser, polarity normalisation to 1=pressed,
// hold-time debounce counter, accepted level and registered rise/fall pulses.
module fret_debounce_ch
    import fret_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw pin level when the button is released; the synchroniser resets to it.
    localparam logic             RAW_IDLE = RAW_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0]       sync_q;
    logic             s_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Synchronised level normalised so that 1 means pressed.
    assign s_c = RAW_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    // Next-state: count while the input disagrees with the accepted level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s_c == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s_c;
            cnt_d    = '0;
            rise_d   = s_c;
            fall_d   = ~s_c;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register; reset aborts any count in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {2{RAW_IDLE}};
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule : fret_debounce_ch

// File: rtl/fret_input_conditioner.sv
// Guitar-controller input conditioner: debounced fret levels for the SoC PIO,
// fret press/release pulses and a strum-press pulse.
// Optional feature macro FRET_PRESS_COUNT_EN: 16-bit wrapping count of accepted
// fret presses on press_count; without it press_count is tied to zero.
// reset_reset_n asserts asynchronously; its release is expected to be already
// synchronous to clk_clk (system reset controller).
module fret_input_conditioner
    import fret_input_pkg::*;
#(
    parameter int unsigned N_FRETS         = N_FRETS_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [N_FRETS-1:0]     fret_raw,
    input  logic                   strum_raw,
    output logic [N_FRETS-1:0]     frets_db,
    output logic [N_FRETS-1:0]     press_pulse,
    output logic [N_FRETS-1:0]     release_pulse,
    output logic                   strum_pulse,
    output logic [PRESS_CNT_W-1:0] press_count
);

    logic strum_level;
    logic strum_fall;
    logic unused_strum;

    // One independent channel per fret.
    for (genvar i = 0; i < int'(N_FRETS); i++) begin : g_fret
        fret_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
        ) u_ch (
            .clk        (clk_clk),
            .rst_n      (reset_reset_n),
            .raw        (fret_raw[i]),
            .level      (frets_db[i]),
            .rise_pulse (press_pulse[i]),
            .fall_pulse (release_pulse[i])
        );
    end

    // Strum bar channel; only the accepted press is reported.
    fret_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
    ) u_strum (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .raw        (strum_raw),
        .level      (strum_level),
        .rise_pulse (strum_pulse),
        .fall_pulse (strum_fall)
    );

    // Strum level and release are intentionally not exported.
    assign unused_strum = strum_level ^ strum_fall;

`ifdef FRET_PRESS_COUNT_EN
    logic [PRESS_CNT_W-1:0] press_inc_c;
    logic [PRESS_CNT_W-1:0] press_count_q;

    // Number of fret presses accepted this cycle.
    always_comb begin
        press_inc_c = '0;
        for (int i = 0; i < int'(N_FRETS); i++) begin
            press_inc_c = press_inc_c + PRESS_CNT_W'(press_pulse[i]);
        end
    end

    // Running press total, wraps modulo 2^PRESS_CNT_W.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            press_count_q <= '0;
        end else begin
            press_count_q <= press_count_q + press_inc_c;
        end
    end

    assign press_count = press_count_q;
`else
    assign press_count = '0;
`endif

endmodule : fret_input_conditioner
